// File: rtl/timer_digit_entry_if.sv
// Keypad-side and countdown-side signals of the timer digit entry stage.
interface timer_digit_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       busy;
    logic       load;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] digit_count;
    logic       entry_error;
    logic       locked;

    // Keypad/countdown side: drives keys and busy, observes the entry buffer.
    modport master (
        output key_valid, key_code, busy,
        input  load, min_tens, min_ones, sec_tens, sec_ones,
        input  digit_count, entry_error, locked
    );

    // Entry stage side.
    modport slave (
        input  key_valid, key_code, busy,
        output load, min_tens, min_ones, sec_tens, sec_ones,
        output digit_count, entry_error, locked
    );
endinterface

// File: rtl/timer_digit_entry.sv
// Shifts keypad digits into an MM:SS BCD buffer, validates it on START and
// hands it to the countdown stage with a one-cycle load pulse, then locks out
// entry until the countdown drops busy.
module timer_digit_entry #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned MAX_SEC_TENS = 5
) (
    input  logic                clk,
    input  logic                clr,
    timer_digit_entry_if.slave  bus
);
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned COUNT_W = 3;

    localparam logic [DIGIT_W-1:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR     = 4'd10;
    localparam logic [DIGIT_W-1:0] KEY_START     = 4'd11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENTRY  = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic [1:0]         state,    state_nxt;
    logic [DIGIT_W-1:0] min_tens, min_tens_nxt;
    logic [DIGIT_W-1:0] min_ones, min_ones_nxt;
    logic [DIGIT_W-1:0] sec_tens, sec_tens_nxt;
    logic [DIGIT_W-1:0] sec_ones, sec_ones_nxt;
    logic [COUNT_W-1:0] count,    count_nxt;
    logic               err_nxt;
    logic               load_q;
    logic               err_q;
    logic               locked_q;

    logic is_digit_c;
    logic is_clear_c;
    logic is_start_c;

    // Key decode; codes 12-15 and non-strobed cycles decode to nothing.
    always_comb begin
        is_digit_c = bus.key_valid && (bus.key_code <= KEY_MAX_DIGIT);
        is_clear_c = bus.key_valid && (bus.key_code == KEY_CLEAR);
        is_start_c = bus.key_valid && (bus.key_code == KEY_START);
    end

    // Next-state, buffer and error-pulse logic.
    always_comb begin
        state_nxt    = state;
        min_tens_nxt = min_tens;
        min_ones_nxt = min_ones;
        sec_tens_nxt = sec_tens;
        sec_ones_nxt = sec_ones;
        count_nxt    = count;
        err_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (is_digit_c) begin
                    min_tens_nxt = min_ones;
                    min_ones_nxt = sec_tens;
                    sec_tens_nxt = sec_ones;
                    sec_ones_nxt = bus.key_code;
                    count_nxt    = COUNT_W'(1);
                    state_nxt    = S_ENTRY;
                end else if (is_start_c) begin
                    err_nxt = 1'b1;
                end
            end
            S_ENTRY: begin
                if (is_digit_c) begin
                    // A full buffer holds its value; further digits are dropped.
                    if (count < COUNT_W'(NUM_DIGITS)) begin
                        min_tens_nxt = min_ones;
                        min_ones_nxt = sec_tens;
                        sec_tens_nxt = sec_ones;
                        sec_ones_nxt = bus.key_code;
                        count_nxt    = count + COUNT_W'(1);
                    end
                end else if (is_clear_c) begin
                    min_tens_nxt = '0;
                    min_ones_nxt = '0;
                    sec_tens_nxt = '0;
                    sec_ones_nxt = '0;
                    count_nxt    = '0;
                    state_nxt    = S_IDLE;
                end else if (is_start_c) begin
                    if (sec_tens <= DIGIT_W'(MAX_SEC_TENS)) begin
                        state_nxt = S_LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                state_nxt = S_LOCKED;
            end
            S_LOCKED: begin
                if (!bus.busy) begin
                    min_tens_nxt = '0;
                    min_ones_nxt = '0;
                    sec_tens_nxt = '0;
                    sec_ones_nxt = '0;
                    count_nxt    = '0;
                    state_nxt    = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, buffer and registered status outputs; clr has priority.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= S_IDLE;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            count    <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            min_tens <= min_tens_nxt;
            min_ones <= min_ones_nxt;
            sec_tens <= sec_tens_nxt;
            sec_ones <= sec_ones_nxt;
            count    <= count_nxt;
            load_q   <= (state_nxt == S_LOAD);
            err_q    <= err_nxt;
            locked_q <= (state_nxt == S_LOAD) || (state_nxt == S_LOCKED);
        end
    end

    assign bus.load        = load_q;
    assign bus.entry_error = err_q;
    assign bus.locked      = locked_q;
    assign bus.min_tens    = min_tens;
    assign bus.min_ones    = min_ones;
    assign bus.sec_tens    = sec_tens;
    assign bus.sec_ones    = sec_ones;
    assign bus.digit_count = count;
endmodule

// File: tb/tb_timer_digit_entry.sv
// Scoreboard bench for timer_digit_entry: each driven cycle pushes the
// expected post-edge outputs, which a monitor pops and compares after the edge.
module tb_timer_digit_entry;
    logic clk = 1'b0;
    logic clr = 1'b0;

    timer_digit_entry_if bus ();

    timer_digit_entry #(
        .NUM_DIGITS   (4),
        .MAX_SEC_TENS (5)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;
        logic [2:0]  cnt;
        logic        ld;
        logic        err;
        logic        lk;
    } exp_t;

    exp_t exp_q [$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_step = 0;
    int   n_pop  = 0;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected after its edge.
    task automatic apply(input logic c, input logic kv, input logic [3:0] code,
                         input logic b, input logic [15:0] dig, input logic [2:0] cnt,
                         input logic ld, input logic err, input logic lk);
        exp_t e;
        @(negedge clk);
        clr           = c;
        bus.key_valid = kv;
        bus.key_code  = code;
        bus.busy      = b;
        e.dig = dig; e.cnt = cnt; e.ld = ld; e.err = err; e.lk = lk;
        exp_q.push_back(e);
        n_step++;
        @(posedge clk);
    endtask

    task automatic key(input logic [3:0] code, input logic [15:0] dig, input logic [2:0] cnt,
                       input logic ld, input logic err, input logic lk);
        apply(1'b1, 1'b1, code, 1'b0, dig, cnt, ld, err, lk);
    endtask

    task automatic idle(input logic b, input logic [15:0] dig, input logic [2:0] cnt,
                        input logic ld, input logic err, input logic lk);
        apply(1'b1, 1'b0, 4'd0, b, dig, cnt, ld, err, lk);
    endtask

    // Monitor: compare outputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_pop++;
            check($sformatf("v%0d digits", n_pop),
                  32'({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones}), 32'(e.dig));
            check($sformatf("v%0d digit_count", n_pop), 32'(bus.digit_count), 32'(e.cnt));
            check($sformatf("v%0d load", n_pop),        32'(bus.load),        32'(e.ld));
            check($sformatf("v%0d entry_error", n_pop), 32'(bus.entry_error), 32'(e.err));
            check($sformatf("v%0d locked", n_pop),      32'(bus.locked),      32'(e.lk));
        end
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.busy      = 1'b0;

        // 1. reset, then entry of 1,3,0
        apply(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 0, 0, 0);
        apply(1'b0, 1'b1, 4'd5, 1'b1, 16'h0000, 3'd0, 0, 0, 0);
        key(4'd1, 16'h0001, 3'd1, 0, 0, 0);
        key(4'd3, 16'h0013, 3'd2, 0, 0, 0);
        key(4'd0, 16'h0130, 3'd3, 0, 0, 0);
        idle(1'b0, 16'h0130, 3'd3, 0, 0, 0);

        // 2. saturation at four digits
        key(4'd10, 16'h0000, 3'd0, 0, 0, 0);
        key(4'd1, 16'h0001, 3'd1, 0, 0, 0);
        key(4'd2, 16'h0012, 3'd2, 0, 0, 0);
        key(4'd3, 16'h0123, 3'd3, 0, 0, 0);
        key(4'd4, 16'h1234, 3'd4, 0, 0, 0);
        key(4'd5, 16'h1234, 3'd4, 0, 0, 0);

        // 3. valid START, lockout while busy, release on busy low
        key(4'd10, 16'h0000, 3'd0, 0, 0, 0);
        key(4'd0, 16'h0000, 3'd1, 0, 0, 0);
        key(4'd1, 16'h0001, 3'd2, 0, 0, 0);
        key(4'd3, 16'h0013, 3'd3, 0, 0, 0);
        key(4'd0, 16'h0130, 3'd4, 0, 0, 0);
        key(4'd11, 16'h0130, 3'd4, 1, 0, 1);
        idle(1'b1, 16'h0130, 3'd4, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) apply(1'b1, 1'b1, 4'd7,  1'b1, 16'h0130, 3'd4, 0, 0, 1);
            else if (i == 6) apply(1'b1, 1'b1, 4'd10, 1'b1, 16'h0130, 3'd4, 0, 0, 1);
            else if (i == 8) apply(1'b1, 1'b1, 4'd11, 1'b1, 16'h0130, 3'd4, 0, 0, 1);
            else idle(1'b1, 16'h0130, 3'd4, 0, 0, 1);
        end
        idle(1'b0, 16'h0000, 3'd0, 0, 0, 0);

        // 4. invalid START (seconds tens 7), then CLEAR
        key(4'd1, 16'h0001, 3'd1, 0, 0, 0);
        key(4'd7, 16'h0017, 3'd2, 0, 0, 0);
        key(4'd5, 16'h0175, 3'd3, 0, 0, 0);
        key(4'd11, 16'h0175, 3'd3, 0, 1, 0);
        idle(1'b0, 16'h0175, 3'd3, 0, 0, 0);
        key(4'd10, 16'h0000, 3'd0, 0, 0, 0);

        // 5. START in IDLE, ignored codes, unstrobed keys, busy in ENTRY
        key(4'd11, 16'h0000, 3'd0, 0, 1, 0);
        idle(1'b0, 16'h0000, 3'd0, 0, 0, 0);
        key(4'd10, 16'h0000, 3'd0, 0, 0, 0);
        for (int c = 12; c < 16; c++) key(4'(c), 16'h0000, 3'd0, 0, 0, 0);
        key(4'd9, 16'h0009, 3'd1, 0, 0, 0);
        for (int c = 12; c < 16; c++) key(4'(c), 16'h0009, 3'd1, 0, 0, 0);
        apply(1'b1, 1'b0, 4'd4, 1'b1, 16'h0009, 3'd1, 0, 0, 0);
        apply(1'b1, 1'b0, 4'd11, 1'b0, 16'h0009, 3'd1, 0, 0, 0);
        // boundary: seconds tens exactly 5 is accepted
        key(4'd5, 16'h0095, 3'd2, 0, 0, 0);
        key(4'd9, 16'h0959, 3'd3, 0, 0, 0);
        key(4'd11, 16'h0959, 3'd3, 1, 0, 1);
        // busy never raised: back to IDLE one cycle after LOCKED entered
        idle(1'b0, 16'h0959, 3'd3, 0, 0, 1);
        idle(1'b0, 16'h0000, 3'd0, 0, 0, 0);

        // 6. reset during LOAD and during LOCKED
        key(4'd2, 16'h0002, 3'd1, 0, 0, 0);
        key(4'd11, 16'h0002, 3'd1, 1, 0, 1);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 3'd0, 0, 0, 0);
        key(4'd4, 16'h0004, 3'd1, 0, 0, 0);
        key(4'd11, 16'h0004, 3'd1, 1, 0, 1);
        idle(1'b1, 16'h0004, 3'd1, 0, 0, 1);
        idle(1'b1, 16'h0004, 3'd1, 0, 0, 1);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 3'd0, 0, 0, 0);
        idle(1'b1, 16'h0000, 3'd0, 0, 0, 0);
        key(4'd6, 16'h0006, 3'd1, 0, 0, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("vectors_popped", 32'(n_pop), 32'(n_step));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/timer_digit_entry.md
Name: timer_digit_entry

Overview:
Keypad-to-timer entry stage in TimerInput, sitting directly downstream of the keypad scan counter and debouncer.
- Accepts one decoded key per strobe and shifts digits into a 4-digit BCD MM:SS buffer.
- Validates the value on START and hands it to the countdown stage with a one-cycle load pulse.
- Locks out entry while the countdown runs.

Parameters:
NUM_DIGITS, 4, number of BCD digits held (fixed MM:SS layout; only 4 supported)
MAX_SEC_TENS, 5, largest legal seconds-tens digit; START is rejected above it

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-low reset (clr=0 resets on the next rising edge)
key_valid  input  1  one-cycle strobe: key_code is valid this cycle
key_code  input  4  0-9 digit; 10 = CLEAR; 11 = START; 12-15 ignored
busy  input  1  countdown running (from downstream timer)
load  output  1  one-cycle pulse: min_tens..sec_ones valid for downstream capture
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
digit_count  output  3  digits entered, 0..4
entry_error  output  1  one-cycle pulse on a rejected START
locked  output  1  high in LOAD and LOCKED states

Behaviour:
Reset (clr=0 at a rising edge):
- All digits=0, digit_count=0, load=0, entry_error=0, state=IDLE, locked=0.
- Reset has priority over every other event, including mid-LOAD and LOCKED.

States: IDLE, ENTRY, LOAD, LOCKED.
- IDLE: digit key -> shift in, digit_count=1, go ENTRY. CLEAR has no effect. START -> entry_error pulse, stay IDLE.
- ENTRY, digit key with digit_count<4: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code; digit_count+1.
- ENTRY, digit key with digit_count==4: ignored. Buffer and count unchanged; no wrap-around.
- ENTRY, CLEAR: all digits=0, digit_count=0, go IDLE.
- ENTRY, START with sec_tens<=MAX_SEC_TENS: go LOAD.
- ENTRY, START with sec_tens>MAX_SEC_TENS: entry_error=1 for exactly one cycle; buffer retained; stay ENTRY.
- LOAD: load=1 for exactly this one cycle; digits stable; busy not sampled; next state LOCKED.
- LOCKED: all keys ignored, including CLEAR and START. When busy==0 is sampled: digits=0, digit_count=0, go IDLE.
  - Downstream raises busy in the cycle after load. If it never does, the block returns to IDLE one cycle after LOCKED is entered.

Timing and decode rules:
- Latency: key strobe at edge N -> outputs updated after edge N; START at edge N -> load high during cycle N+1.
- Keys with key_valid=0 are ignored. Codes 12-15 are ignored in all states.
- Only one key per strobe, so no simultaneous key events. busy changing during ENTRY/IDLE is ignored.
- Digits are always BCD 0-9. Minutes are unrestricted, 00-99.
- load and entry_error are never high in the same cycle.

Test Plan:
1. Reset/entry: clr=0 for 2 cycles, then keys 1,3,0 -> digits 0,1,3,0, digit_count=3; digits update one cycle after each strobe.
2. Saturation: keys 1,2,3,4,5 -> buffer 1,2,3,4 (MM:SS 12:34); digit_count=4; the 5th key leaves the buffer unchanged.
3. Valid START: enter 0,1,3,0, START.
   - Expect load=1 for one cycle with 01:30 on outputs.
   - Drive busy=1 for 10 cycles; a digit 7 sent during those cycles is ignored.
   - busy=0 -> digits 00:00, digit_count=0, locked=0 the next cycle.
4. Invalid START:
   - Enter 1,7,5 (sec_tens=7), START -> entry_error one-cycle pulse, load stays 0, buffer still 01:75, state ENTRY.
   - CLEAR -> 00:00, count 0.
5. START in IDLE -> entry_error pulse, no load. Codes 12-15 strobed -> no change.
6. Reset mid-operation: assert clr=0 in the LOAD cycle and again during LOCKED -> load drops, all outputs return to reset values on the next edge.
